// File: rtl/dsp_pkg.sv
// Shared constants and the round/shift/saturate helper for the DSP result path.
package dsp_pkg;

    // DSP48A1 register stages that sit between operand issue and P.
    localparam int unsigned A1REG = 1;
    localparam int unsigned B1REG = 1;
    localparam int unsigned MREG  = 1;
    localparam int unsigned PREG  = 1;

    localparam int unsigned DSP_LATENCY = ((A1REG > B1REG) ? A1REG : B1REG) + MREG + PREG;
    localparam int unsigned DSP_P_W     = 48;
    localparam int unsigned DSP_OUT_W   = 18;

    // Helper works at a fixed wide width; callers sign-extend P into it.
    localparam int unsigned MAX_P_W = 64;

    typedef logic signed [MAX_P_W:0] wide_t;

    // Returns {sat, r}: r = round-half-up(P / 2^shift) clamped to out_w signed bits.
    function automatic logic [MAX_P_W:0] sat_round(input logic signed [MAX_P_W-1:0] p,
                                                   input int unsigned          shift,
                                                   input int unsigned          out_w);
        wide_t ext;
        wide_t rnd;
        wide_t r;
        wide_t max_v;
        wide_t min_v;
        logic  sat;
        ext = wide_t'(p);
        rnd = '0;
        if (shift > 0) begin
            rnd = wide_t'(1) << (shift - 1);
        end
        r     = (ext + rnd) >>> shift;
        max_v = (wide_t'(1) << (out_w - 1)) - wide_t'(1);
        min_v = -(wide_t'(1) << (out_w - 1));
        sat   = 1'b0;
        if (r > max_v) begin
            r   = max_v;
            sat = 1'b1;
        end else if (r < min_v) begin
            r   = min_v;
            sat = 1'b1;
        end
        return {sat, r[MAX_P_W-1:0]};
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with occupancy count; read data is zero while empty.
module result_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [4:0]       count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]       count_q, count_d;
    logic             push, pop, full;

    always_comb begin
        full     = (count_q == 5'(DEPTH));
        pop      = rd_en_i && (count_q != '0);
        // A pop in the same cycle makes room even when full.
        push     = wr_en_i && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + 5'(push) - 5'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o    = count_q;

endmodule

// File: rtl/dsp_result_collector.sv
// Captures DSP P/CARRYOUT after the fixed pipeline latency, rounds/saturates it and
// buffers it behind a valid/ready port; issue is credit-controlled since the DSP cannot stall.
module dsp_result_collector
    import dsp_pkg::*;
#(
    parameter int unsigned LATENCY = DSP_LATENCY,
    parameter int unsigned P_W     = DSP_P_W,
    parameter int unsigned OUT_W   = DSP_OUT_W,
    parameter int unsigned SHIFT   = 0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [P_W-1:0]   dsp_p,
    input  logic             dsp_carryout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             out_carry,
    output logic [3:0]       in_flight,
    output logic [4:0]       fifo_count,
    output logic             drop_err
);

    localparam int unsigned ENTRY_W = OUT_W + 2;

    logic [LATENCY-1:0] tag_q, tag_d;
    logic [3:0]         in_flight_q, in_flight_d;
    logic               drop_err_q, drop_err_d;
    logic               accept, capture;
    logic [5:0]         credits_used;

    logic signed [MAX_P_W-1:0] p_ext;
    logic [MAX_P_W:0]          proc_res;
    logic [ENTRY_W-1:0]        wr_entry;
    logic [ENTRY_W-1:0]        head_entry;
    logic                      unused_proc_bits;

    // Credits come from registered counts only, so a pop frees a slot one cycle later.
    assign credits_used = {1'b0, fifo_count} + {2'b00, in_flight_q};
    assign issue_ready  = rstn && (credits_used < 6'(DEPTH));
    assign accept       = issue_valid && issue_ready;
    assign capture      = tag_q[LATENCY-1];

    always_comb begin
        tag_d[0] = accept;
        for (int i = 1; i < LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        in_flight_d = in_flight_q + 4'(accept) - 4'(capture);
        drop_err_d  = drop_err_q || (issue_valid && !issue_ready);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_q       <= '0;
            in_flight_q <= '0;
            drop_err_q  <= 1'b0;
        end else begin
            tag_q       <= tag_d;
            in_flight_q <= in_flight_d;
            drop_err_q  <= drop_err_d;
        end
    end

    always_comb begin
        p_ext    = MAX_P_W'($signed(dsp_p));
        proc_res = sat_round(p_ext, SHIFT, OUT_W);
        wr_entry = {proc_res[MAX_P_W], dsp_carryout, proc_res[OUT_W-1:0]};
    end

    assign unused_proc_bits = ^proc_res[MAX_P_W-1:OUT_W];

    result_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en_i   (capture),
        .wr_data_i (wr_entry),
        .rd_en_i   (out_ready),
        .rd_valid_o(out_valid),
        .rd_data_o (head_entry),
        .count_o   (fifo_count)
    );

    assign out_sat   = head_entry[ENTRY_W-1];
    assign out_carry = head_entry[ENTRY_W-2];
    assign out_data  = head_entry[OUT_W-1:0];
    assign in_flight = in_flight_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_dsp_result_collector.sv
// Bench for dsp_result_collector: two instances (SHIFT=0 and SHIFT=4) share stimulus and
// are compared each cycle against a queue-based reference plus constant vectors.
module tb_dsp_result_collector;

    localparam int unsigned LAT   = 3;
    localparam int unsigned P_W   = 48;
    localparam int unsigned OUT_W = 18;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rstn;
    logic             issue_valid;
    logic [P_W-1:0]   dsp_p;
    logic             dsp_carryout;
    logic             out_ready;

    logic             issue_ready_a, out_valid_a, out_sat_a, out_carry_a, drop_err_a;
    logic [OUT_W-1:0] out_data_a;
    logic [3:0]       in_flight_a;
    logic [4:0]       fifo_count_a;
    logic             issue_ready_b, out_valid_b, out_sat_b, out_carry_b, drop_err_b;
    logic [OUT_W-1:0] out_data_b;
    logic [3:0]       in_flight_b;
    logic [4:0]       fifo_count_b;

    dsp_result_collector #(
        .LATENCY(LAT), .P_W(P_W), .OUT_W(OUT_W), .SHIFT(0), .DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_ready(issue_ready_a),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_sat(out_sat_a),
        .out_carry(out_carry_a), .in_flight(in_flight_a), .fifo_count(fifo_count_a),
        .drop_err(drop_err_a)
    );

    dsp_result_collector #(
        .LATENCY(LAT), .P_W(P_W), .OUT_W(OUT_W), .SHIFT(4), .DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_ready(issue_ready_b),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_sat(out_sat_b),
        .out_carry(out_carry_b), .in_flight(in_flight_b), .fifo_count(fifo_count_b),
        .drop_err(drop_err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [P_W-1:0] p;
        logic           c;
    } ent_t;

    typedef struct {
        longint p;
        bit     c;
        longint d0;
        bit     s0;
        longint d4;
        bit     s4;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc    = 0;
    ent_t   mq[$];
    int     pend[$];
    bit     m_drop = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: round half up by 2^sh, then clamp to OUT_W signed bits.
    function automatic longint proc(input logic [P_W-1:0] p48, input int sh, output bit sat);
        longint p, r, hi, lo;
        p  = longint'($signed(p48));
        r  = (sh > 0) ? ((p + (longint'(1) << (sh - 1))) >>> sh) : p;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -hi - 1;
        sat = 1'b0;
        if (r > hi) begin
            r = hi; sat = 1'b1;
        end else if (r < lo) begin
            r = lo; sat = 1'b1;
        end
        return r;
    endfunction

    task automatic compare_all();
        bit     exp_rdy, s0, s4;
        longint d0, d4;
        exp_rdy = (mq.size() + pend.size()) < DEPTH;
        check("ready_a", longint'(issue_ready_a), longint'(exp_rdy));
        check("ready_b", longint'(issue_ready_b), longint'(exp_rdy));
        check("valid_a", longint'(out_valid_a), longint'(mq.size() > 0));
        check("valid_b", longint'(out_valid_b), longint'(mq.size() > 0));
        check("count_a", longint'(fifo_count_a), longint'(mq.size()));
        check("count_b", longint'(fifo_count_b), longint'(mq.size()));
        check("inflight_a", longint'(in_flight_a), longint'(pend.size()));
        check("inflight_b", longint'(in_flight_b), longint'(pend.size()));
        check("drop_a", longint'(drop_err_a), longint'(m_drop));
        check("drop_b", longint'(drop_err_b), longint'(m_drop));
        if (mq.size() > 0) begin
            d0 = proc(mq[0].p, 0, s0);
            d4 = proc(mq[0].p, 4, s4);
            check("data_a", longint'($signed(out_data_a)), d0);
            check("sat_a", longint'(out_sat_a), longint'(s0));
            check("data_b", longint'($signed(out_data_b)), d4);
            check("sat_b", longint'(out_sat_b), longint'(s4));
            check("carry_a", longint'(out_carry_a), longint'(mq[0].c));
            check("carry_b", longint'(out_carry_b), longint'(mq[0].c));
        end
    endtask

    // One clock: advance the reference with the inputs seen at the edge, then compare.
    task automatic tick();
        bit   rdy, pop;
        ent_t e;
        rdy = (mq.size() + pend.size()) < DEPTH;
        pop = out_ready && (mq.size() > 0);
        if (issue_valid && !rdy) m_drop = 1'b1;
        e.p = dsp_p;
        e.c = dsp_carryout;
        @(posedge clk);
        cyc++;
        if (pop) void'(mq.pop_front());
        if (pend.size() > 0 && pend[0] == cyc) begin
            void'(pend.pop_front());
            mq.push_back(e);
        end
        if (issue_valid && rdy) pend.push_back(cyc + LAT);
        #1;
        compare_all();
    endtask

    task automatic tick_ramp();
        dsp_p        = P_W'(1000 + cyc);
        dsp_carryout = cyc[0];
        tick();
    endtask

    vec_t   vecs[10];
    longint last_pop;

    initial begin
        vecs[0] = '{1000,     1'b0, 1000,    1'b0, 63,     1'b0};
        vecs[1] = '{200000,   1'b1, 131071,  1'b1, 12500,  1'b0};
        vecs[2] = '{-200000,  1'b0, -131072, 1'b1, -12500, 1'b0};
        vecs[3] = '{24,       1'b1, 24,      1'b0, 2,      1'b0};
        vecs[4] = '{23,       1'b0, 23,      1'b0, 1,      1'b0};
        vecs[5] = '{-24,      1'b1, -24,     1'b0, -1,     1'b0};
        vecs[6] = '{131071,   1'b0, 131071,  1'b0, 8192,   1'b0};
        vecs[7] = '{131072,   1'b1, 131071,  1'b1, 8192,   1'b0};
        vecs[8] = '{-131073,  1'b0, -131072, 1'b1, -8192,  1'b0};
        vecs[9] = '{(longint'(1) << 47) - 1, 1'b1, 131071, 1'b1, 131071, 1'b1};

        rstn = 1'b0; issue_valid = 1'b0; dsp_p = '0; dsp_carryout = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_valid", longint'(out_valid_a), 0);
        check("rst_count", longint'(fifo_count_a), 0);
        check("rst_data", longint'(out_data_a), 0);
        check("rst_drop", longint'(drop_err_b), 0);
        rstn = 1'b1;
        #1;
        check("rst_ready", longint'(issue_ready_a), 1);

        // Latency and processing vectors
        foreach (vecs[i]) begin
            issue_valid = 1'b1; dsp_p = P_W'(vecs[i].p); dsp_carryout = vecs[i].c;
            tick();
            issue_valid = 1'b0;
            for (int k = 1; k < LAT; k++) begin
                tick();
                check("lat_early", longint'(out_valid_a), 0);
            end
            tick();
            check("vec_valid", longint'(out_valid_a), 1);
            check("vec_data0", longint'($signed(out_data_a)), vecs[i].d0);
            check("vec_sat0", longint'(out_sat_a), longint'(vecs[i].s0));
            check("vec_data4", longint'($signed(out_data_b)), vecs[i].d4);
            check("vec_sat4", longint'(out_sat_b), longint'(vecs[i].s4));
            check("vec_carry", longint'(out_carry_a), longint'(vecs[i].c));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Backpressure: four credits, then the fifth issue is dropped
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_ready_hi", longint'(issue_ready_a), 1);
            tick_ramp();
        end
        check("bp_ready_lo", longint'(issue_ready_a), 0);
        tick_ramp();
        check("bp_drop", longint'(drop_err_a), 1);
        issue_valid = 1'b0;
        repeat (LAT) tick_ramp();
        check("bp_full", longint'(fifo_count_a), 4);
        out_ready = 1'b1;
        repeat (4) tick_ramp();
        out_ready = 1'b0;

        // Capture and pop on the same edge with two entries stored
        issue_valid = 1'b1;
        repeat (3) tick_ramp();
        issue_valid = 1'b0;
        repeat (2) tick_ramp();
        check("cp_pre", longint'(fifo_count_a), 2);
        out_ready = 1'b1;
        tick_ramp();
        check("cp_hold", longint'(fifo_count_a), 2);
        last_pop = -1;
        for (int i = 0; i < 8 && out_valid_a; i++) begin
            check("cp_order", longint'($signed(out_data_a) > last_pop), 1);
            check("cp_carry", longint'(out_carry_a), longint'(($signed(out_data_a) - 1000) & 1));
            last_pop = longint'($signed(out_data_a));
            tick_ramp();
        end
        check("cp_empty", longint'(fifo_count_a), 0);
        out_ready = 1'b0;

        // Reset with two stored and two in flight
        issue_valid = 1'b1;
        repeat (2) tick_ramp();
        issue_valid = 1'b0;
        repeat (2) tick_ramp();
        issue_valid = 1'b1;
        repeat (2) tick_ramp();
        issue_valid = 1'b0;
        check("pre_rst_count", longint'(fifo_count_a), 2);
        check("pre_rst_inflight", longint'(in_flight_a), 2);
        rstn = 1'b0;
        @(posedge clk);
        #3;
        check("mid_rst_valid", longint'(out_valid_a), 0);
        check("mid_rst_inflight", longint'(in_flight_b), 0);
        rstn = 1'b1;
        mq.delete(); pend.delete(); m_drop = 1'b0;
        #1;
        check("post_rst_ready", longint'(issue_ready_a), 1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("no_stale", longint'(out_valid_a || out_valid_b), 0);
        end

        // Randomized traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            longint r;
            issue_valid  = ($urandom_range(0, 9) < 6);
            out_ready    = ($urandom_range(0, 9) < 5);
            dsp_carryout = $urandom_range(0, 1);
            r = longint'({$urandom, $urandom});
            dsp_p = P_W'(r >>> $urandom_range(16, 46));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dsp_result_collector.md
Name: dsp_result_collector

Overview:
- Downstream stage of the DSP48A1 slice model. Consumes the P and CARRYOUT outputs.
- Tracks in-flight operations through the fixed DSP pipeline latency and captures each result on the cycle it becomes valid.
- Rounds, shifts and saturates each result to a narrow signed word, then buffers it in a small FIFO with a valid/ready output handshake.
- Uses credit-based issue control, because the DSP pipeline cannot stall.

Parameters:
- LATENCY, 3: posedges from operand issue until the matching P is presented on dsp_p (1..8).
- P_W, 48: DSP P width.
- OUT_W, 18: signed output width (2..P_W).
- SHIFT, 0: arithmetic right shift applied to P before saturation (0..P_W-OUT_W).
- DEPTH, 4: result FIFO depth (power of 2, 2..16).

Ports:
- clk in 1: rising-edge clock.
- rstn in 1: asynchronous, active-low reset.
- issue_valid in 1: operands launched into the DSP this cycle.
- issue_ready out 1: collector can guarantee storage for a new issue.
- dsp_p in P_W: DSP P output.
- dsp_carryout in 1: DSP CARRYOUT.
- out_valid out 1: FIFO head valid.
- out_ready in 1: consumer accepts the head.
- out_data out OUT_W: processed result.
- out_sat out 1: head result was saturated.
- out_carry out 1: CARRYOUT captured with the head result.
- in_flight out 4: issues accepted and not yet captured.
- fifo_count out 5: entries stored.
- drop_err out 1: sticky; an issue was attempted while issue_ready was low.

Behaviour:
- Reset (rstn low, async): tag pipe, FIFO pointers, counts and drop_err all clear. Outputs are out_valid=0, out_data=0, out_sat=0, out_carry=0, in_flight=0, fifo_count=0, drop_err=0, issue_ready=1 (only once rstn is released).
- Reset mid-operation discards in-flight tags and stored entries. No stale capture follows release.
- Accept: issue_valid && issue_ready at posedge t pushes a 1 into the LATENCY-deep tag shift register. Otherwise a 0 is pushed.
- Capture: at posedge t+LATENCY the tag reaches the last stage. dsp_p and dsp_carryout are sampled that same edge and written to the FIFO. out_valid can go high immediately after that edge.
- Back-to-back issues on consecutive cycles give consecutive captures in issue order.
- Processing is combinational before the FIFO write:
  - If SHIFT>0: r = (P + 2^(SHIFT-1)) >>> SHIFT, computed at P_W+1 bits (round half up, signed). If SHIFT=0: r = P.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. sat=1 when clamped.
- Credit rule: issue_ready = (fifo_count + in_flight) < DEPTH.
  - Computed from registered counts only. A same-cycle pop does not free a credit until the next cycle.
  - The FIFO therefore never overflows.
- drop_err: set when issue_valid && !issue_ready. The dropped issue is not tagged. Cleared only by reset.
- Pop: out_valid && out_ready at posedge removes the head.
  - Simultaneous capture and pop: both occur; fifo_count unchanged.
  - Pop on empty is ignored.
- out_data, out_sat and out_carry hold stable while out_valid && !out_ready.
- in_flight: +1 on accept, -1 on capture. Unchanged when both happen in the same cycle.
- Pointers wrap modulo DEPTH.

Decomposition:
- Shared package dsp_pkg holds:
  - the P_W and OUT_W defaults,
  - a function sat_round(P, SHIFT, OUT_W) returning {sat, r},
  - the LATENCY constant derived from the DSP register-stage parameters (A1REG/B1REG, MREG, PREG).
- One sub-module: result_fifo (sync FIFO, width OUT_W+2, DEPTH entries, count output, async active-low reset).
- The tag pipe, credit logic and processing live in the top.

Test Plan:
- Reset: hold rstn=0 mid-stream with 2 in flight and 2 stored, then release. Required: out_valid=0, in_flight=0, fifo_count=0, issue_ready=1, and no capture in the following 8 cycles.
- Latency/pass-through (SHIFT=0): issue at cycle 0 with dsp_p=1000 presented at cycle 3. Required: out_data=1000, out_sat=0, out_valid high after edge 3.
- Saturation: P=200000 gives out_data=131071, out_sat=1. P=-200000 (48-bit two's complement) gives -131072, out_sat=1.
- Rounding (SHIFT=4): P=24 gives 2; P=23 gives 1; P=-24 gives -1. All with out_sat=0.
- Backpressure/credit (DEPTH=4, out_ready=0): issue every cycle. Required: issue_ready drops after 4 accepts, the 5th issue_valid sets drop_err=1, and fifo_count reaches exactly 4.
- Simultaneous capture and pop: with FIFO at 2 and out_ready=1, capture lands. Required: fifo_count stays 2, data emerges in issue order, and out_carry matches dsp_carryout sampled at each capture.
